// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID register: owns the PC, keeps one imem request in flight, holds for ID stalls, squashes on redirect.
// Optional FETCH_PERF_EN adds saturating stall-cycle and flush counters.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_stall,
   input  logic        i_flush,
   input  logic [31:0] i_redirect_pc,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_gnt,
   input  logic        i_imem_rvalid,
   input  logic [31:0] i_imem_rdata,
   output logic [31:0] o_if_id_pc,
   output logic [31:0] o_if_id_instr,
   output logic        o_if_id_valid,
   output logic [1:0]  o_fsm_state
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] o_stall_cycles,
   output logic [31:0] o_flush_count
`endif
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_WAIT  = 2'd1,
      S_HELD  = 2'd2,
      S_DROP  = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_pc;
   logic [31:0] w_pc_nxt;
   logic [31:0] r_buf_pc;
   logic [31:0] r_buf_instr;
   logic [31:0] r_if_id_pc;
   logic [31:0] r_if_id_instr;
   logic        r_if_id_valid;
   logic        w_deliver;
   logic        w_capture;
   logic [31:0] w_deliver_pc;
   logic [31:0] w_deliver_instr;

   // imem handshake: a request is accepted on the cycle o_imem_req & i_imem_gnt;
   // exactly one i_imem_rvalid follows, no earlier than the next cycle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_FETCH;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (i_flush) begin
         case (r_state)
            S_FETCH: w_state_nxt = i_imem_gnt    ? S_DROP  : S_FETCH;
            S_WAIT:  w_state_nxt = i_imem_rvalid ? S_FETCH : S_DROP;
            S_HELD:  w_state_nxt = S_FETCH;
            S_DROP:  w_state_nxt = i_imem_rvalid ? S_FETCH : S_DROP;
            default: w_state_nxt = S_FETCH;
         endcase
      end else begin
         case (r_state)
            S_FETCH: w_state_nxt = i_imem_gnt ? S_WAIT : S_FETCH;
            S_WAIT:  if (i_imem_rvalid) w_state_nxt = i_stall ? S_HELD : S_FETCH;
            S_HELD:  w_state_nxt = i_stall ? S_HELD : S_FETCH;
            S_DROP:  w_state_nxt = i_imem_rvalid ? S_FETCH : S_DROP;
            default: w_state_nxt = S_FETCH;
         endcase
      end
   end

   // Request is gated by reset so nothing is issued while imem is also held in reset.
   always_comb begin
      o_imem_req      = (r_state == S_FETCH) && i_rst_n;
      w_deliver       = 1'b0;
      w_capture       = 1'b0;
      w_deliver_pc    = r_pc;
      w_deliver_instr = i_imem_rdata;
      if (!i_flush) begin
         case (r_state)
            S_WAIT: begin
               w_deliver = i_imem_rvalid && !i_stall;
               w_capture = i_imem_rvalid && i_stall;
            end
            S_HELD: begin
               w_deliver       = !i_stall;
               w_deliver_pc    = r_buf_pc;
               w_deliver_instr = r_buf_instr;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_pc_nxt = r_pc;
      if (i_flush)        w_pc_nxt = i_redirect_pc & 32'hFFFF_FFFC;
      else if (w_deliver) w_pc_nxt = r_pc + 32'd4;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_pc <= RESET_PC;
      else          r_pc <= w_pc_nxt;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_buf_pc    <= 32'd0;
         r_buf_instr <= 32'd0;
      end else if (i_flush || w_deliver) begin
         r_buf_pc    <= 32'd0;
         r_buf_instr <= 32'd0;
      end else if (w_capture) begin
         r_buf_pc    <= r_pc;
         r_buf_instr <= i_imem_rdata;
      end
   end

   // A bubble keeps the old PC so ID never sees a PC change without a valid instruction.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_if_id_pc    <= 32'd0;
         r_if_id_instr <= NOP_INSTR;
         r_if_id_valid <= 1'b0;
      end else if (i_flush) begin
         r_if_id_instr <= NOP_INSTR;
         r_if_id_valid <= 1'b0;
      end else if (!i_stall) begin
         if (w_deliver) begin
            r_if_id_pc    <= w_deliver_pc;
            r_if_id_instr <= w_deliver_instr;
            r_if_id_valid <= 1'b1;
         end else begin
            r_if_id_instr <= NOP_INSTR;
            r_if_id_valid <= 1'b0;
         end
      end
   end

   assign o_imem_addr   = r_pc;
   assign o_if_id_pc    = r_if_id_pc;
   assign o_if_id_instr = r_if_id_instr;
   assign o_if_id_valid = r_if_id_valid;
   assign o_fsm_state   = r_state;

`ifdef FETCH_PERF_EN
   logic [31:0] r_stall_cycles;
   logic [31:0] r_flush_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_stall_cycles <= 32'd0;
         r_flush_count  <= 32'd0;
      end else begin
         if (i_stall && !i_flush && (r_stall_cycles != 32'hFFFF_FFFF))
            r_stall_cycles <= r_stall_cycles + 32'd1;
         if (i_flush && (r_flush_count != 32'hFFFF_FFFF))
            r_flush_count <= r_flush_count + 32'd1;
      end
   end

   assign o_stall_cycles = r_stall_cycles;
   assign o_flush_count  = r_flush_count;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: imem responder returning the address as data, vector table for streaming/stall, hand sequences for flush/wrap/reset.
// Build with FETCH_PERF_EN defined to also exercise the performance counters.
`timescale 1ns/1ps
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [1:0] ST_FETCH = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_HELD  = 2'd2;
   localparam logic [1:0] ST_DROP  = 2'd3;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        flush;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_instr;
   logic        if_id_valid;
   logic [1:0]  fsm_state;
`ifdef FETCH_PERF_EN
   logic [31:0] stall_cycles;
   logic [31:0] flush_count;
`endif

   int          n_chk;
   int          n_pass;
   int          lat_extra;
   logic        sb_en;
   logic [31:0] exp_q[$];

   fetch_stage dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_stall       (stall),
      .i_flush       (flush),
      .i_redirect_pc (redirect_pc),
      .o_imem_req    (imem_req),
      .o_imem_addr   (imem_addr),
      .i_imem_gnt    (imem_gnt),
      .i_imem_rvalid (imem_rvalid),
      .i_imem_rdata  (imem_rdata),
      .o_if_id_pc    (if_id_pc),
      .o_if_id_instr (if_id_instr),
      .o_if_id_valid (if_id_valid),
      .o_fsm_state   (fsm_state)
`ifdef FETCH_PERF_EN
      ,
      .o_stall_cycles(stall_cycles),
      .o_flush_count (flush_count)
`endif
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic wait_pc(input logic [31:0] target, input int budget);
      int k;
      k = 0;
      while (!(if_id_valid === 1'b1 && if_id_pc === target) && k < budget) begin
         @(negedge clk);
         k++;
      end
      n_chk++;
      if (k < budget) n_pass++;
      else $display("FAIL wait_pc: got pc %h valid %b expected valid pc %h within %0d cycles",
                    if_id_pc, if_id_valid, target, budget);
   endtask

   // imem responder: grants every request, answers after 1+lat_extra cycles with data = address
   initial begin
      logic        pend;
      logic [31:0] pend_addr;
      int          cnt;
      pend = 1'b0; pend_addr = 32'd0; cnt = 0;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
      forever begin
         @(negedge clk);
         imem_gnt    = 1'b0;
         imem_rvalid = 1'b0;
         if (!rst_n) begin
            pend = 1'b0;
         end else if (pend) begin
            check("req_while_outstanding", {31'd0, imem_req}, 32'd0);
            if (cnt == 0) begin
               imem_rvalid = 1'b1;
               imem_rdata  = pend_addr;
               pend        = 1'b0;
            end else begin
               cnt--;
            end
         end else if (imem_req) begin
            imem_gnt  = 1'b1;
            pend      = 1'b1;
            pend_addr = imem_addr;
            cnt       = lat_extra;
         end
      end
   end

   // scoreboard: each new IF/ID instruction pops the expected PC; instr must equal its PC
   initial begin
      logic        prev_v;
      logic [31:0] prev_pc;
      logic [31:0] e;
      prev_v = 1'b0; prev_pc = 32'd0;
      forever begin
         @(negedge clk);
         if (rst_n && sb_en && if_id_valid && (!prev_v || if_id_pc != prev_pc)) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               $display("FAIL sb_unexpected: got pc %h instr %h expected no delivery", if_id_pc, if_id_instr);
            end else begin
               e = exp_q.pop_front();
               check("sb_pc", if_id_pc, e);
               check("sb_instr", if_id_instr, e);
            end
         end
         prev_v  = if_id_valid;
         prev_pc = if_id_pc;
      end
   end

   typedef struct {
      logic        stall;
      logic        flush;
      logic [31:0] redir;
      logic [1:0]  exp_state;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_pc;
      logic [31:0] exp_instr;
   } vec_t;

   vec_t vecs[8];

   initial begin
      n_chk = 0; n_pass = 0; lat_extra = 0; sb_en = 1'b1;
      rst_n = 1'b0; stall = 1'b0; flush = 1'b0; redirect_pc = 32'd0;

      // row i is driven at one negedge and checked at the next
      vecs[0] = '{1'b0, 1'b0, 32'h0, ST_WAIT,  1'b0, 32'h0, 1'b0, 32'h0, NOP};
      vecs[1] = '{1'b0, 1'b0, 32'h0, ST_FETCH, 1'b1, 32'h4, 1'b1, 32'h0, 32'h0};
      vecs[2] = '{1'b0, 1'b0, 32'h0, ST_WAIT,  1'b0, 32'h0, 1'b0, 32'h0, NOP};
      vecs[3] = '{1'b0, 1'b0, 32'h0, ST_FETCH, 1'b1, 32'h8, 1'b1, 32'h4, 32'h4};
      vecs[4] = '{1'b1, 1'b0, 32'h0, ST_WAIT,  1'b0, 32'h0, 1'b1, 32'h4, 32'h4};
      vecs[5] = '{1'b1, 1'b0, 32'h0, ST_HELD,  1'b0, 32'h0, 1'b1, 32'h4, 32'h4};
      vecs[6] = '{1'b1, 1'b0, 32'h0, ST_HELD,  1'b0, 32'h0, 1'b1, 32'h4, 32'h4};
      vecs[7] = '{1'b0, 1'b0, 32'h0, ST_FETCH, 1'b1, 32'hC, 1'b1, 32'h8, 32'h8};

      repeat (3) @(negedge clk);
      check("rst_valid", {31'd0, if_id_valid}, 32'd0);
      check("rst_instr", if_id_instr, NOP);
      check("rst_pc", if_id_pc, 32'd0);
      check("rst_req", {31'd0, imem_req}, 32'd0);
      check("rst_state", {30'd0, fsm_state}, {30'd0, ST_FETCH});
      check("rst_addr", imem_addr, 32'd0);

      exp_q.push_back(32'h0);
      exp_q.push_back(32'h4);
      exp_q.push_back(32'h8);
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         stall = vecs[i].stall;
         flush = vecs[i].flush;
         redirect_pc = vecs[i].redir;
         @(negedge clk);
         check($sformatf("vec%0d_state", i), {30'd0, fsm_state}, {30'd0, vecs[i].exp_state});
         check($sformatf("vec%0d_req", i), {31'd0, imem_req}, {31'd0, vecs[i].exp_req});
         if (vecs[i].exp_req) check($sformatf("vec%0d_addr", i), imem_addr, vecs[i].exp_addr);
         check($sformatf("vec%0d_valid", i), {31'd0, if_id_valid}, {31'd0, vecs[i].exp_valid});
         check($sformatf("vec%0d_pc", i), if_id_pc, vecs[i].exp_pc);
         check($sformatf("vec%0d_instr", i), if_id_instr, vecs[i].exp_instr);
      end

      // flush while WAIT, stale response arrives two cycles later
      exp_q.push_back(32'hC);
      @(posedge clk);
      #1 lat_extra = 2;
      repeat (2) @(negedge clk);
      check("c_delivered_pc", if_id_pc, 32'hC);
      @(negedge clk);
      check("flush_pre_state", {30'd0, fsm_state}, {30'd0, ST_WAIT});
      flush = 1'b1;
      redirect_pc = 32'h100;
      @(negedge clk);
      flush = 1'b0;
      lat_extra = 0;
      check("drop_state", {30'd0, fsm_state}, {30'd0, ST_DROP});
      check("drop_req", {31'd0, imem_req}, 32'd0);
      check("drop_valid", {31'd0, if_id_valid}, 32'd0);
      check("drop_instr", if_id_instr, NOP);
      @(negedge clk);
      check("drop_hold_state", {30'd0, fsm_state}, {30'd0, ST_DROP});
      check("drop_hold_req", {31'd0, imem_req}, 32'd0);
      @(negedge clk);
      check("redir_req", {31'd0, imem_req}, 32'd1);
      check("redir_addr", imem_addr, 32'h100);
      exp_q.push_back(32'h100);
      wait_pc(32'h100, 10);

      // flush and stall together, FETCH with grant
      stall = 1'b1;
      flush = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      @(negedge clk);
      stall = 1'b0;
      flush = 1'b0;
      check("fs_valid", {31'd0, if_id_valid}, 32'd0);
      check("fs_instr", if_id_instr, NOP);
      check("fs_pc", if_id_pc, 32'h100);
      check("fs_state", {30'd0, fsm_state}, {30'd0, ST_DROP});
      @(negedge clk);
      check("wrap_req0", {31'd0, imem_req}, 32'd1);
      check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
      exp_q.push_back(32'hFFFF_FFFC);
      exp_q.push_back(32'h0);
      repeat (2) @(negedge clk);
      check("wrap_req1", {31'd0, imem_req}, 32'd1);
      check("wrap_addr1", imem_addr, 32'h0);
      repeat (2) @(negedge clk);
      check("post_wrap_addr", imem_addr, 32'h4);

      // unaligned redirect is forced to a word boundary
      flush = 1'b1;
      redirect_pc = 32'h103;
      @(negedge clk);
      flush = 1'b0;
      check("ua_state", {30'd0, fsm_state}, {30'd0, ST_DROP});
      @(negedge clk);
      check("ua_req", {31'd0, imem_req}, 32'd1);
      check("ua_addr", imem_addr, 32'h100);
      exp_q.push_back(32'h100);
      wait_pc(32'h100, 10);
      check("sb_drained", exp_q.size(), 32'd0);

      // asynchronous reset mid-run takes effect without a clock edge
      sb_en = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", {31'd0, if_id_valid}, 32'd0);
      check("arst_instr", if_id_instr, NOP);
      check("arst_pc", if_id_pc, 32'd0);
      check("arst_req", {31'd0, imem_req}, 32'd0);
      check("arst_state", {30'd0, fsm_state}, {30'd0, ST_FETCH});
`ifdef FETCH_PERF_EN
      check("arst_stall_cycles", stall_cycles, 32'd0);
      check("arst_flush_count", flush_count, 32'd0);
`endif
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      check("rearm_addr", imem_addr, 32'd0);
`ifdef FETCH_PERF_EN
      stall = 1'b1;
      repeat (5) @(negedge clk);
      stall = 1'b0;
      flush = 1'b1;
      redirect_pc = 32'h0;
      repeat (2) @(negedge clk);
      flush = 1'b0;
      @(negedge clk);
      check("perf_stall_cycles", stall_cycles, 32'd5);
      check("perf_flush_count", flush_count, 32'd2);
      #2 rst_n = 1'b0;
      #1;
      check("perf_rst_stall", stall_cycles, 32'd0);
      check("perf_rst_flush", flush_count, 32'd0);
      check("perf_rst_valid", {31'd0, if_id_valid}, 32'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;
`endif
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the 5-stage RV32I core; sits directly upstream of the ID-stage data hazard unit.
- Owns the PC and issues one instruction-memory request at a time (variable latency).
- Presents {pc, instr, valid} to ID, freezes them while ID asserts stall, and discards in-flight fetches on a control-flow redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INSTR, 32'h0000_0013, encoding driven on o_if_id_instr for bubbles (ADDI x0,x0,0).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_stall  in  1  ID stall request from the data hazard unit; IF/ID must hold.
- i_flush  in  1  redirect request (taken branch/JAL/JALR resolved in ID).
- i_redirect_pc  in  32  target PC, sampled when i_flush=1; bits[1:0] ignored (treated as 00).
- o_imem_req  out  1  fetch request valid.
- o_imem_addr  out  32  fetch address, word aligned.
- i_imem_gnt  in  1  request accepted this cycle.
- i_imem_rvalid  in  1  response valid, exactly one per granted request, earliest the cycle after grant.
- i_imem_rdata  in  32  fetched instruction.
- o_if_id_pc  out  32  PC of instruction in IF/ID.
- o_if_id_instr  out  32  instruction in IF/ID.
- o_if_id_valid  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset (async, i_rst_n=0):
  - pc=RESET_PC, state=FETCH, hold buffer empty.
  - o_if_id_valid=0, o_if_id_instr=NOP_INSTR, o_if_id_pc=0.
  - o_imem_req=0 while reset is asserted.
- At most one outstanding imem request. o_imem_req and o_imem_addr are registered-state driven; no combinational path from i_imem_rvalid to o_imem_req.
- States:
  - FETCH: o_imem_req=1, o_imem_addr=pc. On i_imem_gnt go to WAIT.
  - WAIT: o_imem_req=0.
    - i_imem_rvalid & !i_stall: IF/ID <= {pc, rdata, 1}; pc <= pc+4; go to FETCH.
    - i_imem_rvalid & i_stall: hold buffer <= {pc, rdata}; go to HELD.
  - HELD: o_imem_req=0. On !i_stall: IF/ID <= buffer (valid=1); pc <= pc+4; buffer cleared; go to FETCH.
  - DROP: waiting for the response of a stale request. On i_imem_rvalid the data is discarded; go to FETCH.
- IF/ID update rule:
  - i_stall=1: all o_if_id_* hold their values.
  - i_stall=0 with no new instruction delivered this cycle: IF/ID loads a bubble (valid=0, instr=NOP_INSTR; pc holds its old value).
- Flush (priority over stall and all state actions):
  - IF/ID <= bubble; pc <= {i_redirect_pc[31:2], 2'b00}; hold buffer cleared.
  - Next state by current state:
    - FETCH with gnt this cycle: DROP.
    - FETCH without gnt: FETCH.
    - WAIT with rvalid this cycle: data discarded; FETCH.
    - WAIT without rvalid: DROP.
    - HELD: FETCH.
    - DROP without rvalid: stays DROP.
    - DROP with rvalid: FETCH.
  - The new PC is never fetched before the stale response has returned.
- Throughput: with zero-wait imem (gnt=1, rvalid the next cycle), one instruction per 2 cycles.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- Reset mid-fetch: the pending response is lost. Imem is reset by the same i_rst_n.

Optional Feature:
- FETCH_PERF_EN defined: adds outputs o_stall_cycles[31:0] and o_flush_count[31:0].
  - o_stall_cycles increments each cycle i_stall=1 and i_flush=0.
  - o_flush_count increments each cycle i_flush=1.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- FETCH_PERF_EN undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset release, zero-wait imem returning addr as data -> addrs 0x0,0x4,0x8 requested; IF/ID valid every other cycle with pc=instr=0x0,0x4,0x8.
- i_stall=1 for 3 cycles while IF/ID holds pc 0x4 and a response for 0x8 arrives -> IF/ID stays 0x4 for 3 cycles, state HELD; first cycle after stall drops, IF/ID shows pc 0x8.
- i_flush=1, redirect 0x100 in WAIT, rvalid 2 cycles later -> stale data never reaches IF/ID; next o_imem_addr=0x100 only after stale rvalid.
- i_flush and i_stall both 1 -> IF/ID becomes bubble (valid=0, instr=0x13); pc=0x100.
- Redirect to 0xFFFF_FFFC, then sequential fetch -> next address 0x0000_0000; redirect 0x103 -> fetch address 0x100.
- With FETCH_PERF_EN: 5 stall cycles and 2 flushes -> o_stall_cycles=5, o_flush_count=2; async reset mid-test -> both 0 and o_if_id_valid=0 immediately.
